// File: rtl/core_pkg.sv
// Shared core definitions: reset PC, NOP encoding and the fetch queue entry type.
package core_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch front-end bundle: redirect, imem request/response and decode channels.
interface ifetch_queue_if;
  import core_pkg::*;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, req_ready, rsp_valid, rsp_data, inst_ready,
    output req_valid, req_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, req_ready, rsp_valid, rsp_data, inst_ready,
    input  req_valid, req_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of {pc, inst}; flush empties it, and the head
// output holds the last popped entry while empty.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  fetch_entry_t       din,
  output fetch_entry_t       dout,
  output logic [CNT_W-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  fetch_entry_t     last_q, last_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state for storage, pointers, count and last-popped entry
  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (flush) begin
      wr_d  = {PTR_W{1'b0}};
      rd_d  = {PTR_W{1'b0}};
      cnt_d = {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + PTR_W'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop) begin
        last_d = mem_q[rd_q];
        rd_d   = rd_q + PTR_W'(1);
      end else begin
        rd_d = rd_q;
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
      end
      last_q <= '{pc: 32'h0000_0000, inst: 32'h0000_0000};
      wr_q   <= {PTR_W{1'b0}};
      rd_q   <= {PTR_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q  <= mem_d;
      last_q <= last_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout  = (cnt_q == {CNT_W{1'b0}}) ? last_q : mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited sequential requests, in-order
// response buffering with PCs, and redirect flush with stale-response dropping.
module ifetch_queue
  import core_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = core_pkg::RESET_PC,
  parameter int          CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  ifetch_queue_if.master bus
);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] occ_s;
  logic [CNT_W:0]   credit_s;
  logic             req_valid_s, fire_s, rsp_keep_s, rsp_drop_s, push_s, pop_s;
  fetch_entry_t     din_s, dout_s;

  // Request credit, handshake decode and counter/PC next-state
  always_comb begin
    credit_s = {1'b0, occ_s} + {1'b0, outst_q} + {1'b0, drop_q};
    if (rst && !bus.redirect && (credit_s < (CNT_W+1)'(DEPTH))) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    fire_s     = req_valid_s && bus.req_ready;
    rsp_keep_s = bus.rsp_valid && (drop_q == {CNT_W{1'b0}});
    rsp_drop_s = bus.rsp_valid && (drop_q != {CNT_W{1'b0}});
    push_s     = rsp_keep_s && !bus.redirect;
    pop_s      = (occ_s != {CNT_W{1'b0}}) && bus.inst_ready && !bus.redirect;
    din_s      = '{pc: rsp_pc_q, inst: bus.rsp_data};

    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (bus.redirect) begin
      // A response arriving now is either stale or the oldest outstanding one;
      // both cases reduce the combined discard count by one.
      fetch_pc_d = word_align(bus.redirect_pc);
      rsp_pc_d   = word_align(bus.redirect_pc);
      drop_d     = drop_q + outst_q - CNT_W'(bus.rsp_valid);
      outst_d    = {CNT_W{1'b0}};
    end else begin
      fetch_pc_d = fire_s ? fetch_pc_q + 32'd4 : fetch_pc_q;
      rsp_pc_d   = rsp_keep_s ? rsp_pc_q + 32'd4 : rsp_pc_q;
      outst_d    = outst_q + CNT_W'(fire_s) - CNT_W'(rsp_keep_s);
      drop_d     = drop_q - CNT_W'(rsp_drop_s);
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= {CNT_W{1'b0}};
      drop_q     <= {CNT_W{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.redirect),
    .din   (din_s),
    .dout  (dout_s),
    .count (occ_s)
  );

  assign bus.req_valid  = req_valid_s;
  assign bus.req_addr   = fetch_pc_q;
  assign bus.inst_valid = (occ_s != {CNT_W{1'b0}});
  assign bus.inst       = dout_s.inst;
  assign bus.inst_pc    = dout_s.pc;

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch front end of the core: generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel.
- Collects in-order responses and buffers them with their PCs in a small FIFO.
- Presents instructions to the decode stage over a valid/ready channel.
- On a taken jump/branch from EX, flushes everything and discards responses that are still in flight.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of requests in flight plus entries buffered (power of 2, ≥2).
- RESET_PC, 32'h00400000, fetch address after reset.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy, outstanding and drop counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- redirect  in  1  taken jump/branch from EX; single-cycle pulse.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0).
- req_valid  out  1  fetch request valid.
- req_ready  in  1  imem accepts request.
- req_addr  out  32  word-aligned fetch address.
- rsp_valid  in  1  imem response valid; in order, at most one per cycle, no backpressure.
- rsp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes.
- inst  out  32  instruction word.
- inst_pc  out  32  PC of inst.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC.
  - FIFO empty; outstanding=0, drop=0.
  - req_valid=0, inst_valid=0, inst=0, inst_pc=0.
  - First request may assert in the first cycle after rst deasserts.
- State:
  - fetch_pc: next address to request.
  - rsp_pc: PC for the next accepted response.
  - outstanding: requests accepted but not answered.
  - drop: stale responses still to discard.
  - occupancy: FIFO count.
- Request:
  - req_valid = !redirect && (occupancy + outstanding + drop) < DEPTH; combinational from registered state and redirect.
  - req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += 4 and outstanding += 1.
  - Address wraps modulo 2^32.
- Response:
  - When rsp_valid and drop > 0: drop -= 1; data discarded.
  - Otherwise: push {rsp_pc, rsp_data}, rsp_pc += 4, outstanding -= 1.
  - A request fire and a response push in the same cycle leave outstanding unchanged.
  - The credit rule guarantees the FIFO is never full on push. rsp_valid with outstanding=0 and drop=0 is a protocol error; the bench asserts on it.
- Output:
  - inst_valid = occupancy != 0; inst/inst_pc show the FIFO head.
  - Pop on inst_valid && inst_ready.
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
  - No bypass: minimum latency is request accept at cycle N, response at N+k, inst_valid at N+k+1.
  - inst and inst_pc hold their last value when the FIFO is empty.
- Redirect (highest priority):
  - In the cycle redirect=1:
    - FIFO cleared.
    - fetch_pc = rsp_pc = {redirect_pc[31:2], 2'b00}.
    - drop = drop + outstanding − (rsp_valid ? 1 : 0).
    - outstanding = 0.
  - Any pop that cycle is ignored.
  - req_valid=0 that cycle; a request may issue the next cycle if credits allow.
  - inst_valid=0 the cycle after redirect.
  - Back-to-back redirects: the last one wins and drop accumulates correctly.
- Counters never overflow; occupancy + outstanding + drop ≤ DEPTH always holds (bench assertion).

Decomposition:
- Shared package core_pkg holds:
  - RESET_PC constant (also used by the core PC register).
  - NOP encoding 32'h00000013.
  - fetch_entry_t = {pc[31:0], inst[31:0]}.
- One natural sub-module: fetch_fifo, a DEPTH-entry synchronous FIFO.
  - Inputs: push, pop, flush, din.
  - Outputs: dout, count, async active-low reset.
  - Head/tail pointers wrap at DEPTH.

Test Plan:
- Reset then imem ready every cycle with 1-cycle response latency, decode always ready → req_addr 0x00400000, 0x00400004, …; inst_pc matches; one instruction per cycle in steady state.
- inst_ready=0 held → exactly 4 requests issued, req_valid drops, inst_valid stays 1 with pc 0x00400000; release → in-order drain and fetch resumes.
- 3 requests in flight, redirect with redirect_pc=0x00400103 → the next 3 responses are dropped; next req_addr=0x00400100; first inst_pc=0x00400100.
- Redirect in the same cycle as rsp_valid, with outstanding=2 → drop=1; only one further response discarded.
- Two redirects on consecutive cycles (0x00400200 then 0x00400300) → only 0x00400300 onward is delivered; all stale responses are discarded.
- rst pulled low mid-stream with the FIFO full → outputs clear immediately; after release, fetch restarts at 0x00400000.
